tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent tick channels (1..8).
REQ-002 Parameter WIDTH, default 11: counter and period width in bits (4..32).
REQ-003 Parameter DEFAULT_PERIOD, default 2047: reset value of every channel period register.
REQ-004 Parameter MIN_PERIOD, default 64: ramp floor for channel 0 (used only with TICK_RAMP_EN).
REQ-005 Parameter RAMP_TICKS, default 16: channel-0 ticks per ramp step (used only with TICK_RAMP_EN).
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 pause  input  1  freezes all counters while high.
REQ-009 step  input  1  while paused, advances all counters by one count for that cycle.
REQ-010 restart  input  1  synchronous reload of all counters from their period registers.
REQ-011 per_wr  input  1  period write strobe.
REQ-012 per_ch  input  $clog2(CHANNELS) (min 1)  channel selected for write and readback.
REQ-013 per_data  input  WIDTH  period value to write.
REQ-014 per_rd  output  WIDTH  combinational readback of the period register selected by per_ch.
REQ-015 enable  output  CHANNELS  per-channel registered one-cycle tick pulse.

Function
REQ-016 Each channel SHALL hold a WIDTH-bit down-counter cnt[c] and a WIDTH-bit period register per[c].
REQ-017 An advance occurs in a cycle when (pause==0) or (pause==1 and step==1).
REQ-018 On an advance edge with cnt[c]==0: cnt[c] <= per[c] and enable[c] <= 1; with cnt[c]!=0: cnt[c] <= cnt[c]-1 and enable[c] <= 0.
REQ-019 On an edge without advance, cnt[c] SHALL hold and enable[c] <= 0; no tick is ever emitted or held while frozen.
REQ-020 Tick spacing SHALL be per[c]+1 advance cycles; per[c]==0 SHALL give enable[c] high every advance cycle.
REQ-021 step while pause==0 SHALL have no additional effect (one count per cycle only).
REQ-022 restart SHALL set every cnt[c] <= per[c] and enable <= 0, overriding pause, step and any tick that edge.
REQ-023 per_wr SHALL write per[per_ch] <= per_data on that edge; a reload on the same edge SHALL use the old per value.
REQ-024 A written period takes effect at that channel's next reload or restart; the running count is not altered.
REQ-025 per_wr with per_ch >= CHANNELS SHALL be ignored; per_rd SHALL read 0 for such per_ch.
REQ-026 Counter arithmetic SHALL be unsigned WIDTH-bit; decrement never occurs from 0 (reload instead), so no wrap.

Reset
REQ-027 While reset==0: cnt[c] = DEFAULT_PERIOD, per[c] = DEFAULT_PERIOD, enable = 0, ramp state cleared, independent of clk.
REQ-028 Reset asserted mid-count SHALL discard the count and any written periods immediately.
REQ-029 After reset release, first enable[c] SHALL occur after the (DEFAULT_PERIOD+1)-th advance edge.

Configuration
REQ-030 Macro TICK_RAMP_EN, when defined, SHALL add a ramp counter of $clog2(RAMP_TICKS)+1 bits counting channel-0 ticks.
REQ-031 With TICK_RAMP_EN: on the edge producing the RAMP_TICKS-th channel-0 tick, ramp counter <= 0 and per[0] <= per[0]-1 if per[0] > MIN_PERIOD, else hold.
REQ-032 With TICK_RAMP_EN: per_wr to channel 0 on the same edge as a ramp step SHALL win; restart SHALL clear the ramp counter.
REQ-033 Without TICK_RAMP_EN: no ramp logic; per[0] changes only by per_wr; MIN_PERIOD and RAMP_TICKS unused.

Verification
REQ-034 CHANNELS=2, DEFAULT_PERIOD=3, release reset, pause=0 -> enable[0],[1] high after edges 4, 8, 12, each exactly one cycle.
REQ-035 per_wr ch1 data 0 mid-count -> old spacing until next ch1 reload, then enable[1] high every cycle; ch0 unchanged.
REQ-036 pause=1 for 5 cycles when cnt==1 -> enable stays 0 throughout; with step pulsed twice -> one tick on second step edge.
REQ-037 restart on the edge cnt[0]==0 -> no tick that edge; next enable[0] after per[0]+1 further edges.
REQ-038 TICK_RAMP_EN, per[0]=66, MIN_PERIOD=64, RAMP_TICKS=2 -> per_rd(ch0) reads 65 after 2nd tick, 64 after 4th, stays 64 after 6th.
REQ-039 reset asserted asynchronously between edges mid-count -> enable 0 and per_rd = DEFAULT_PERIOD before next clk edge.

Source files
------------

// File: rtl/tick_gen.sv
// tick_gen: CHANNELS independent down-counting tick dividers with pause/step/restart and period readback.
// Defining TICK_RAMP_EN adds a channel-0 period ramp-down towards MIN_PERIOD every RAMP_TICKS ticks.
module tick_gen #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 11,
  parameter int DEFAULT_PERIOD = 2047,
  parameter int MIN_PERIOD     = 64,
  parameter int RAMP_TICKS     = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pause,
  input  logic                step,
  input  logic                restart,
  input  logic                per_wr,
  input  logic [CW-1:0]       per_ch,
  input  logic [WIDTH-1:0]    per_data,
  output logic [WIDTH-1:0]    per_rd,
  output logic [CHANNELS-1:0] enable
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_PERIOD);

  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [WIDTH-1:0] per [CHANNELS];
  logic             advance;

  assign advance = ~pause | step;

  // Selecting through a compare loop makes out-of-range channels read back as zero.
  always_comb begin
    per_rd = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(per_ch) == c) per_rd = per[c];
    end
  end

`ifdef TICK_RAMP_EN
  localparam int RW = $clog2(RAMP_TICKS) + 1;
  localparam logic [WIDTH-1:0] MINP = WIDTH'(MIN_PERIOD);

  logic [RW-1:0] ramp_cnt;
  logic          tick0;
  logic          ramp_last;

  assign tick0     = advance & ~restart & (cnt[0] == '0);
  assign ramp_last = (ramp_cnt == RW'(RAMP_TICKS - 1));
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = ^{MIN_PERIOD, RAMP_TICKS};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= DEF;
        per[c] <= DEF;
      end
      enable <= '0;
`ifdef TICK_RAMP_EN
      ramp_cnt <= '0;
`endif
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (restart) begin
          cnt[c]    <= per[c];
          enable[c] <= 1'b0;
        end else if (advance) begin
          if (cnt[c] == '0) begin
            cnt[c]    <= per[c];
            enable[c] <= 1'b1;
          end else begin
            cnt[c]    <= cnt[c] - WIDTH'(1);
            enable[c] <= 1'b0;
          end
        end else begin
          enable[c] <= 1'b0;
        end
      end
`ifdef TICK_RAMP_EN
      if (restart) begin
        ramp_cnt <= '0;
      end else if (tick0) begin
        if (ramp_last) begin
          ramp_cnt <= '0;
          if (per[0] > MINP) per[0] <= per[0] - WIDTH'(1);
        end else begin
          ramp_cnt <= ramp_cnt + RW'(1);
        end
      end
`endif
      // Placed after the ramp update so a host write to channel 0 takes priority.
      for (int c = 0; c < CHANNELS; c++) begin
        if (per_wr && (int'(per_ch) == c)) per[c] <= per_data;
      end
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed self-checking bench for tick_gen (CHANNELS=2, DEFAULT_PERIOD=3) plus a 3-channel instance for out-of-range access.
module tb_tick_gen;

  logic        clk;
  logic        reset;
  logic        pause;
  logic        step;
  logic        restart;
  logic        per_wr;
  logic [0:0]  per_ch;
  logic [10:0] per_data;
  logic [10:0] per_rd;
  logic [1:0]  enable;

  logic        per_wr3;
  logic [1:0]  per_ch3;
  logic [7:0]  per_data3;
  logic [7:0]  per_rd3;
  logic [2:0]  enable3;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  tick_gen #(
    .CHANNELS(2), .WIDTH(11), .DEFAULT_PERIOD(3), .MIN_PERIOD(64), .RAMP_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .step(step), .restart(restart),
    .per_wr(per_wr), .per_ch(per_ch), .per_data(per_data), .per_rd(per_rd), .enable(enable)
  );

  tick_gen #(
    .CHANNELS(3), .WIDTH(8), .DEFAULT_PERIOD(3), .MIN_PERIOD(1), .RAMP_TICKS(4)
  ) dut3 (
    .clk(clk), .reset(reset), .pause(pause), .step(step), .restart(restart),
    .per_wr(per_wr3), .per_ch(per_ch3), .per_data(per_data3), .per_rd(per_rd3), .enable(enable3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input string tag, input int n, input logic [1:0] p [8]);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk(tag, 32'(enable), 32'(p[i]));
    end
  endtask

  initial begin
    reset = 1'b0; pause = 1'b0; step = 1'b0; restart = 1'b0;
    per_wr = 1'b0; per_ch = 1'b0; per_data = '0;
    per_wr3 = 1'b0; per_ch3 = 2'd3; per_data3 = '0;

    #12;
    chk("rst_enable", 32'(enable), 0);
    chk("rst_per0", 32'(per_rd), 3);
    per_ch = 1'b1; #1;
    chk("rst_per1", 32'(per_rd), 3);
    chk("rst_per_oor", 32'(per_rd3), 0);
    per_ch = 1'b0;

    @(posedge clk); #1;
    reset = 1'b1;

    // First ticks after edges 4, 8, 12; dut3 gets an ignored and a valid write meanwhile.
    for (int e = 1; e <= 12; e++) begin
      per_wr3   = (e <= 2);
      per_ch3   = (e == 1) ? 2'd3 : 2'd2;
      per_data3 = (e == 1) ? 8'd7 : 8'd9;
      cyc();
      chk("tick_spacing", 32'(enable), (e % 4 == 0) ? 32'd3 : 32'd0);
    end
    per_wr3 = 1'b0;
    per_ch3 = 2'd3; #1; chk("oor_read", 32'(per_rd3), 0);
    per_ch3 = 2'd0; #1; chk("oor_wr_ch0", 32'(per_rd3), 3);
    per_ch3 = 2'd1; #1; chk("oor_wr_ch1", 32'(per_rd3), 3);
    per_ch3 = 2'd2; #1; chk("wr_ch2", 32'(per_rd3), 9);
    per_ch3 = 2'd3;

    cyc(); chk("edge13", 32'(enable), 0);

    // ch1 period 0 written mid-count: old spacing until its next reload.
    per_wr = 1'b1; per_ch = 1'b1; per_data = 11'd0;
    cyc();
    per_wr = 1'b0;
    chk("edge14", 32'(enable), 0);
    chk("per1_wr0", 32'(per_rd), 0);
    seq("per1_zero", 6, '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00});
    per_ch = 1'b0; #1;
    chk("per0_kept", 32'(per_rd), 3);

    // Write on the same edge as a ch1 reload: reload uses the old period 0.
    per_wr = 1'b1; per_ch = 1'b1; per_data = 11'd3;
    cyc();
    per_wr = 1'b0;
    chk("edge21", 32'(enable), 2);
    seq("wr_at_reload", 5, '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00});
    chk("per1_wr3", 32'(per_rd), 3);
    per_ch = 1'b0;

    // cnt0==1, cnt1==3: pause five edges, then two steps.
    pause = 1'b1;
    seq("paused", 5, '{default: 2'b00});
    step = 1'b1; cyc(); chk("step1", 32'(enable), 0);
    step = 1'b0; cyc(); chk("step_gap", 32'(enable), 0);
    step = 1'b1; cyc(); chk("step2", 32'(enable), 1);
    step = 1'b0; cyc(); chk("step_no_hold", 32'(enable), 0);
    pause = 1'b0;

    step = 1'b1; cyc(); chk("step_unpaused", 32'(enable), 0);
    step = 1'b0;
    seq("after_step", 3, '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

    // Restart exactly when cnt0==0.
    seq("pre_restart", 3, '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    restart = 1'b1; cyc(); chk("restart_edge", 32'(enable), 0);
    restart = 1'b0;
    seq("post_restart", 4, '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});

    // New ch0 period 5 takes effect at its next reload; then async reset mid-count.
    per_wr = 1'b1; per_ch = 1'b0; per_data = 11'd5;
    cyc();
    per_wr = 1'b0;
    chk("edge48", 32'(enable), 0);
    chk("per0_wr5", 32'(per_rd), 5);
    seq("per0_5", 3, '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    #2 reset = 1'b0;
    #1;
    chk("async_rst_enable", 32'(enable), 0);
    chk("async_rst_per0", 32'(per_rd), 3);

`ifdef TICK_RAMP_EN
    @(posedge clk); #1;
    reset = 1'b1;
    per_wr = 1'b1; per_ch = 1'b0; per_data = 11'd66;
    cyc();
    per_wr = 1'b0;
    for (int i = 0; i < 1000 && ticks < 6; i++) begin
      cyc();
      if (enable[0]) begin
        ticks++;
        if (ticks == 2) chk("ramp_tick2", 32'(per_rd), 65);
        if (ticks == 4) chk("ramp_tick4", 32'(per_rd), 64);
        if (ticks == 6) chk("ramp_tick6", 32'(per_rd), 64);
      end
    end
    chk("ramp_tick_count", ticks, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
